// File: rtl/mjpg_stream_parser.sv
// rtl/mjpg_stream_parser.sv - MJPG marker parser with ECS unstuffing and bit window
//
// Purpose: walks an MJPG byte stream, pulses on SOI/EOI, captures SOF0
// height/width, skips length-prefixed segments, and after SOS strips 0xFF00
// stuffing from the entropy-coded segment into a 64-bit MSB-aligned bit
// accumulator that a downstream decoder drains through a 32-bit window.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ivalid/iready    byte handshake, idata is the byte
//   sof, eof         one-cycle pulses after SOI / EOI marker bytes
//   height, width    SOF0 dimensions (truncated to DIM_W), dim_valid qualifies
//   bvalid, bdata    bit window, MSB = oldest bit, zero below bavail
//   bavail           valid bits in the window (0..32)
//   blen             bits consumed this cycle, honoured only when bvalid
//   ecs_done         ECS was terminated by a marker
//   err              sticky protocol error, cleared by SOI or rst
module mjpg_stream_parser #(
  parameter int DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ivalid,
  output logic             iready,
  input  logic [7:0]       idata,
  output logic             sof,
  output logic             eof,
  output logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] width,
  output logic             dim_valid,
  output logic             bvalid,
  output logic [31:0]      bdata,
  output logic [5:0]       bavail,
  input  logic [5:0]       blen,
  output logic             ecs_done,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_SEEK, ST_MARK, ST_LENH, ST_LENL, ST_BODY, ST_ECS, ST_ECSFF
  } state_t;

  typedef enum logic [1:0] {SEG_SKIP, SEG_SOF, SEG_SOS} seg_t;

  state_t state, state_n;
  seg_t   seg, seg_n;

  logic [7:0]  len_hi;
  logic [15:0] remain;
  logic [2:0]  idx;
  logic [15:0] hold_h;
  logic [7:0]  hold_wh;
  logic [63:0] acc;
  logic [6:0]  cnt;

  logic        fire;
  logic        in_ecs;
  logic        push;
  logic [7:0]  push_byte;
  logic        soi;
  logic        eoi;
  logic        err_set;
  logic        ecs_set;
  logic        ecs_clr;
  logic        len_load;
  logic        body_step;
  logic [15:0] len_full;
  logic [15:0] width_full;
  logic        over;
  logic [5:0]  take;
  logic [63:0] acc_n;
  logic [6:0]  cnt_n;

  // Backpressure only applies while bytes can land in the accumulator; a
  // push needs 8 free bits, judged on the registered count.
  assign in_ecs     = (state == ST_ECS) || (state == ST_ECSFF);
  assign iready     = in_ecs ? (cnt <= 7'd56) : 1'b1;
  assign fire       = ivalid & iready;
  assign len_full   = {len_hi, idata};
  assign width_full = {hold_wh, idata};

  assign bdata  = acc[63:32];
  assign bavail = (cnt >= 7'd32) ? 6'd32 : cnt[5:0];
  assign bvalid = (cnt >= 7'd32) || (ecs_done && (cnt != 7'd0));
  // An over-long consume drains what is there and flags the error.
  assign over   = bvalid && (blen > bavail);
  assign take   = !bvalid ? 6'd0 : (over ? bavail : blen);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SEEK;
      seg   <= SEG_SKIP;
    end else begin
      state <= state_n;
      seg   <= seg_n;
    end
  end

  always_comb begin
    state_n   = state;
    seg_n     = seg;
    push      = 1'b0;
    push_byte = idata;
    soi       = 1'b0;
    eoi       = 1'b0;
    err_set   = 1'b0;
    ecs_set   = 1'b0;
    ecs_clr   = 1'b0;
    len_load  = 1'b0;
    body_step = 1'b0;
    if (fire) begin
      case (state)
        ST_SEEK: begin
          if (idata == 8'hFF) state_n = ST_MARK;
        end
        ST_MARK, ST_ECSFF: begin
          if (idata == 8'hFF) begin
            state_n = state;  // fill byte, keep waiting for the marker code
          end else if ((state == ST_ECSFF) && (idata == 8'h00)) begin
            push      = 1'b1;
            push_byte = 8'hFF;
            state_n   = ST_ECS;
          end else begin
            // A real marker inside the ECS terminates it, then decodes as usual.
            ecs_set = (state == ST_ECSFF);
            state_n = ST_SEEK;
            case (idata)
              8'hD8: soi = 1'b1;
              8'hD9: eoi = 1'b1;
              8'hC0: begin seg_n = SEG_SOF;  state_n = ST_LENH; end
              8'hDA: begin seg_n = SEG_SOS;  state_n = ST_LENH; end
              8'h00: err_set = 1'b1;
              8'h01, 8'hD0, 8'hD1, 8'hD2, 8'hD3,
              8'hD4, 8'hD5, 8'hD6, 8'hD7: begin end
              default: begin seg_n = SEG_SKIP; state_n = ST_LENH; end
            endcase
          end
        end
        ST_LENH: state_n = ST_LENL;
        ST_LENL: begin
          if (len_full < 16'd2) begin
            err_set = 1'b1;
            state_n = ST_SEEK;
          end else begin
            len_load = 1'b1;
            // A SOF0 too short to hold both dimensions is skipped, dims untouched.
            if ((seg == SEG_SOF) && (len_full < 16'd7)) begin
              err_set = 1'b1;
              seg_n   = SEG_SKIP;
            end
            if (len_full != 16'd2) begin
              state_n = ST_BODY;
            end else if (seg == SEG_SOS) begin
              state_n = ST_ECS;
              ecs_clr = 1'b1;
            end else begin
              state_n = ST_SEEK;
            end
          end
        end
        ST_BODY: begin
          body_step = 1'b1;
          if (remain == 16'd1) begin
            if (seg == SEG_SOS) begin
              state_n = ST_ECS;
              ecs_clr = 1'b1;
            end else begin
              state_n = ST_SEEK;
            end
          end
        end
        ST_ECS: begin
          if (idata == 8'hFF) state_n = ST_ECSFF;
          else push = 1'b1;
        end
        default: state_n = ST_SEEK;
      endcase
    end
  end

  // Consume shifts the window first; the new byte then lands directly below
  // the bits that survive the consume.
  always_comb begin
    acc_n = acc << take;
    if (push) acc_n = acc_n | ({push_byte, 56'd0} >> (cnt - {1'b0, take}));
    cnt_n = cnt - {1'b0, take} + (push ? 7'd8 : 7'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi    <= 8'd0;
      remain    <= 16'd0;
      idx       <= 3'd0;
      hold_h    <= 16'd0;
      hold_wh   <= 8'd0;
      acc       <= 64'd0;
      cnt       <= 7'd0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      height    <= '0;
      width     <= '0;
      dim_valid <= 1'b0;
      ecs_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      sof <= soi;
      eof <= eoi;
      if (fire && (state == ST_LENH)) len_hi <= idata;
      if (len_load) begin
        remain <= len_full - 16'd2;
        idx    <= 3'd0;
      end
      if (body_step) begin
        remain <= remain - 16'd1;
        if (idx != 3'd5) idx <= idx + 3'd1;
        if (seg == SEG_SOF) begin
          case (idx)
            3'd1: hold_h[15:8] <= idata;
            3'd2: hold_h[7:0]  <= idata;
            3'd3: hold_wh      <= idata;
            3'd4: begin
              height    <= DIM_W'(hold_h);
              width     <= DIM_W'(width_full);
              dim_valid <= 1'b1;
            end
            default: begin end
          endcase
        end
      end
      if (soi) begin
        // New frame: drop undrained bits, dimensions and status.
        acc       <= 64'd0;
        cnt       <= 7'd0;
        err       <= 1'b0;
        ecs_done  <= 1'b0;
        height    <= '0;
        width     <= '0;
        dim_valid <= 1'b0;
      end else begin
        acc <= acc_n;
        cnt <= cnt_n;
        if (err_set || over) err <= 1'b1;
        if (ecs_set) ecs_done <= 1'b1;
        else if (ecs_clr) ecs_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mjpg_stream_parser.sv
// tb/tb_mjpg_stream_parser.sv - self-checking bench for mjpg_stream_parser
module tb_mjpg_stream_parser;
  localparam int DIM_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ivalid = 1'b0;
  logic [7:0]       idata = 8'd0;
  logic [5:0]       blen = 6'd0;
  logic             iready;
  logic             sof;
  logic             eof;
  logic [DIM_W-1:0] height;
  logic [DIM_W-1:0] width;
  logic             dim_valid;
  logic             bvalid;
  logic [31:0]      bdata;
  logic [5:0]       bavail;
  logic             ecs_done;
  logic             err;

  mjpg_stream_parser #(.DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready), .idata(idata),
    .sof(sof), .eof(eof), .height(height), .width(width), .dim_valid(dim_valid),
    .bvalid(bvalid), .bdata(bdata), .bavail(bavail), .blen(blen),
    .ecs_done(ecs_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 0;
  bit rnd_en = 0;
  int sof_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte-level marker walk plus the unstuffed ECS kept as a
  // plain queue of bits, oldest first.
  int m_mode;  // 0 hunt FF, 1 after FF, 2 len hi, 3 len lo, 4 body, 5 ecs, 6 ecs after FF
  int m_kind;  // 0 skipped segment, 1 SOF0, 2 SOS
  int m_len, m_left, m_pos;
  int m_b1, m_b2, m_b3;
  int m_h, m_w;
  bit m_sof, m_eof, m_dimv, m_ecsd, m_err;
  bit mq[$];

  function automatic bit e_iready();
    return !(m_mode == 5 || m_mode == 6) || (mq.size() <= 56);
  endfunction
  function automatic int e_bavail();
    return (mq.size() > 32) ? 32 : mq.size();
  endfunction
  function automatic bit e_bvalid();
    return (mq.size() >= 32) || (m_ecsd && mq.size() > 0);
  endfunction
  function automatic logic [31:0] e_bdata();
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32 && i < mq.size(); i++) r[31-i] = mq[i];
    return r;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_kind = 0; m_len = 0; m_left = 0; m_pos = 0;
    m_h = 0; m_w = 0; m_dimv = 0; m_ecsd = 0; m_err = 0;
    mq.delete();
  endtask

  task automatic m_push(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
  endtask

  task automatic m_enter_ecs();
    m_mode = 5;
    m_ecsd = 0;
  endtask

  task automatic m_marker(input logic [7:0] b);
    m_mode = 0;
    if (b == 8'hD8) begin
      m_sof = 1; m_h = 0; m_w = 0; m_dimv = 0; m_err = 0; m_ecsd = 0;
      mq.delete();
    end else if (b == 8'hD9) m_eof = 1;
    else if (b == 8'hC0) begin m_kind = 1; m_mode = 2; end
    else if (b == 8'hDA) begin m_kind = 2; m_mode = 2; end
    else if (b == 8'h01 || (b >= 8'hD0 && b <= 8'hD7)) m_mode = 0;
    else if (b == 8'h00) m_err = 1;
    else begin m_kind = 0; m_mode = 2; end
  endtask

  task automatic m_byte(input logic [7:0] b);
    case (m_mode)
      0: if (b == 8'hFF) m_mode = 1;
      1: if (b != 8'hFF) m_marker(b);
      2: begin m_len = int'(b) * 256; m_mode = 3; end
      3: begin
        m_len = m_len + int'(b);
        if (m_len < 2) begin
          m_err = 1; m_mode = 0;
        end else begin
          m_left = m_len - 2;
          m_pos = 0;
          if (m_kind == 1 && m_left < 5) begin m_err = 1; m_kind = 0; end
          if (m_left > 0) m_mode = 4;
          else if (m_kind == 2) m_enter_ecs();
          else m_mode = 0;
        end
      end
      4: begin
        if (m_kind == 1) begin
          if (m_pos == 1) m_b1 = int'(b);
          if (m_pos == 2) m_b2 = int'(b);
          if (m_pos == 3) m_b3 = int'(b);
          if (m_pos == 4) begin
            m_h = (m_b1 * 256 + m_b2) % (1 << DIM_W);
            m_w = (m_b3 * 256 + int'(b)) % (1 << DIM_W);
            m_dimv = 1;
          end
        end
        m_pos++;
        m_left--;
        if (m_left == 0) begin
          if (m_kind == 2) m_enter_ecs();
          else m_mode = 0;
        end
      end
      5: if (b == 8'hFF) m_mode = 6; else m_push(b);
      6: begin
        if (b == 8'h00) begin m_push(8'hFF); m_mode = 5; end
        else if (b != 8'hFF) begin m_ecsd = 1; m_marker(b); end
      end
      default: m_mode = 0;
    endcase
  endtask

  bit acc_ok;
  int av, nc;
  always @(posedge clk) begin
    m_sof = 0;
    m_eof = 0;
    if (rst) begin
      m_reset();
    end else begin
      acc_ok = ivalid && e_iready();
      if (e_bvalid()) begin
        av = e_bavail();
        nc = (int'(blen) > av) ? av : int'(blen);
        if (int'(blen) > av) m_err = 1;
        repeat (nc) void'(mq.pop_front());
      end
      if (acc_ok) m_byte(idata);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (sof === 1'b1) sof_seen++;
      chk("iready", iready, e_iready());
      chk("sof", sof, m_sof);
      chk("eof", eof, m_eof);
      chk("height", height, m_h);
      chk("width", width, m_w);
      chk("dim_valid", dim_valid, m_dimv);
      chk("bvalid", bvalid, e_bvalid());
      chk("bavail", bavail, e_bavail());
      chk("bdata", bdata, e_bdata());
      chk("ecs_done", ecs_done, m_ecsd);
      chk("err", err, m_err);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    int guard;
    ok = 0;
    guard = 0;
    if (rnd_en && $urandom_range(0, 3) == 0) idle(1);
    ivalid = 1'b1;
    idata = b;
    while (!ok) begin
      @(negedge clk);
      ok = iready;
      @(posedge clk);
      #1;
      guard++;
      if (!ok && guard > 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: byte 0x%0h not accepted after %0d cycles", b, guard);
        break;
      end
    end
    ivalid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    send(a); send(b);
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic eat(input logic [5:0] n);
    blen = n;
    idle(1);
    blen = 6'd0;
  endtask

  task automatic rand_frame();
    int n;
    logic [7:0] b;
    logic [15:0] hv, wv;
    send2(8'hFF, 8'hD8);
    if ($urandom_range(0, 1) == 1) begin
      n = $urandom_range(0, 4);
      send4(8'hFF, 8'hE0, 8'h00, 8'(n + 2));
      repeat (n) send(8'($urandom));
    end
    hv = 16'($urandom);
    wv = 16'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      send4(8'hFF, 8'hC0, 8'h00, 8'h05);
      repeat (3) send(8'($urandom));
    end else begin
      send4(8'hFF, 8'hC0, 8'h00, 8'h11);
      send(8'h08); send2(hv[15:8], hv[7:0]); send2(wv[15:8], wv[7:0]); send(8'h03);
      repeat (9) send(8'($urandom));
    end
    n = $urandom_range(0, 3);
    send4(8'hFF, 8'hDA, 8'h00, 8'(n + 2));
    repeat (n) send(8'($urandom));
    n = $urandom_range(2, 40);
    repeat (n) begin
      b = 8'($urandom);
      case ($urandom_range(0, 15))
        0: send2(8'hFF, 8'h00);
        1: begin send(8'hFF); send2(8'hFF, 8'h00); end
        2: send2(8'hFF, 8'hD0 + 8'($urandom_range(0, 7)));
        default: if (b == 8'hFF) send2(8'hFF, 8'h00); else send(b);
      endcase
    end
    if ($urandom_range(0, 4) != 0) send2(8'hFF, 8'hD9);
    idle($urandom_range(0, 20));
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    idle(1);
    chk_en = 1;
    idle(2);
    rst = 1'b0;
    chk("rst_iready", iready, 1'b1);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_dim_valid", dim_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    idle(1);

    // SOI
    send2(8'hFF, 8'hD8);
    chk("soi_sof", sof, 1'b1);
    chk("soi_err", err, 1'b0);
    chk("soi_dim_valid", dim_valid, 1'b0);
    idle(1);
    chk("soi_sof_drop", sof, 1'b0);

    // SOF0 480x640, 15 body bytes
    send4(8'hFF, 8'hC0, 8'h00, 8'h11);
    send4(8'h08, 8'h01, 8'hE0, 8'h02);
    send(8'h80);
    chk("sof0_dim_valid", dim_valid, 1'b1);
    chk("sof0_height", height, 12'd480);
    chk("sof0_width", width, 12'd640);
    chk("model_height", m_h, 480);
    send(8'h03);
    for (int i = 0; i < 9; i++) send(8'(8'h40 + i));
    send2(8'hFF, 8'hD9);
    chk("sof0_back_to_seek_eof", eof, 1'b1);

    // SOS + stuffed ECS terminated by EOI
    send4(8'hFF, 8'hDA, 8'h00, 8'h02);
    send4(8'h12, 8'hFF, 8'h00, 8'h34);
    send2(8'hFF, 8'hD9);
    chk("ecs_eof", eof, 1'b1);
    chk("ecs_bvalid", bvalid, 1'b1);
    chk("ecs_bdata", bdata, 32'h12FF3400);
    chk("ecs_bavail", bavail, 6'd24);
    chk("ecs_done", ecs_done, 1'b1);
    chk("model_bdata", e_bdata(), 32'h12FF3400);
    eat(6'd24);
    chk("ecs_drained", bvalid, 1'b0);

    // Backpressure
    send2(8'hFF, 8'hD8);
    send4(8'hFF, 8'hDA, 8'h00, 8'h02);
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    chk("bp_iready_low", iready, 1'b0);
    chk("bp_bdata0", bdata, 32'h10111213);
    chk("model_iready_low", e_iready(), 1'b0);
    eat(6'd32);
    chk("bp_iready_high", iready, 1'b1);
    chk("bp_bdata1", bdata, 32'h14151617);
    for (int i = 8; i < 12; i++) send(8'(8'h10 + i));
    chk("bp_bavail", bavail, 6'd32);
    eat(6'd32);
    chk("bp_bdata2", bdata, 32'h18191A1B);
    eat(6'd32);
    chk("bp_empty", bvalid, 1'b0);

    // Fill bytes and a bad segment length
    s0 = sof_seen;
    send4(8'hFF, 8'hFF, 8'hFF, 8'hD8);
    idle(2);
    chk("fill_single_sof", sof_seen - s0, 1);
    send4(8'hFF, 8'hDB, 8'h00, 8'h01);
    chk("badlen_err", err, 1'b1);
    send2(8'hFF, 8'hD8);
    chk("soi_clears_err", err, 1'b0);

    // Reset in the middle of an ECS holding 40 bits
    send4(8'hFF, 8'hC0, 8'h00, 8'h11);
    send4(8'h08, 8'h00, 8'h10, 8'h00);
    send2(8'h20, 8'h03);
    repeat (9) send(8'h00);
    send4(8'hFF, 8'hDA, 8'h00, 8'h02);
    for (int i = 0; i < 5; i++) send(8'(8'hA1 + i));
    chk("pre_rst_bavail", bavail, 6'd32);
    chk("pre_rst_height", height, 12'd16);
    rst = 1'b1;
    idle(1);
    chk("rst_mid_bvalid", bvalid, 1'b0);
    chk("rst_mid_bavail", bavail, 6'd0);
    chk("rst_mid_iready", iready, 1'b1);
    chk("rst_mid_height", height, 12'd0);
    chk("rst_mid_width", width, 12'd0);
    rst = 1'b0;
    send2(8'hFF, 8'hD8);
    chk("rst_mid_sof", sof, 1'b1);

    // Randomized frames with random consume and input gaps
    rnd_en = 1;
    for (int f = 0; f < 40; f++) rand_frame();
    rnd_en = 0;
    @(posedge clk);
    #2;
    blen = 6'd0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
        if ($urandom_range(0, 2) == 0) blen = 6'd0;
        else blen = 6'($urandom_range(1, 33));
      end
    end
  end

endmodule

// File: doc/mjpg_stream_parser.md
Name: mjpg_stream_parser

Overview:
- Receiving end of the MJPG byte stream produced by the encoder's stuffing stage.
- Accepts a byte stream and locates JPEG markers: SOI, SOF0, SOS, EOI, plus skippable length-prefixed segments.
- Extracts frame height and width from SOF0.
- Removes 0xFF00 byte stuffing in the entropy-coded segment (ECS) and presents the ECS as an MSB-first bit window with variable-length consume, for a downstream Huffman/DCT decoder.

Parameters:
- DIM_W, 12, width of the height/width outputs. The upper bits of the 16-bit SOF0 fields are truncated.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ivalid  in  1  input byte valid
- iready  out  1  input byte accepted when ivalid&iready
- idata  in  8  input byte
- sof  out  1  one-cycle pulse: SOI marker seen
- eof  out  1  one-cycle pulse: EOI marker seen
- height  out  DIM_W  SOF0 line count
- width  out  DIM_W  SOF0 samples per line
- dim_valid  out  1  height/width loaded for the current frame
- bvalid  out  1  bit window valid
- bdata  out  32  bit window, MSB = oldest bit, zero below bavail
- bavail  out  6  valid bits in the window, 0..32
- blen  in  6  bits consumed this cycle, 0..32; honoured only when bvalid
- ecs_done  out  1  level: ECS terminated by a marker
- err  out  1  sticky protocol error, cleared by SOI or rst

Behaviour:
- Reset, synchronous: state=SEEK. All outputs 0 except iready=1. Accumulator count cnt=0. Applies mid-operation too: all state is discarded, and outputs show reset values the cycle after rst.

States:
- SEEK: 0xFF -> MARK. Any other byte is dropped.
- MARK:
  - 0xFF (fill) -> stay.
  - D8 -> sof pulse; clear dims, err, ecs_done and accumulator; -> SEEK.
  - D9 -> eof pulse; -> SEEK.
  - C0 -> LENH with parse flag.
  - DA -> LENH, then ECS.
  - 01 or D0-D7 -> SEEK (standalone, ignored).
  - 00 -> err=1, -> SEEK.
  - Any other byte -> LENH, skip body.
- LENH/LENL: load 16-bit length L.
  - L<2 -> err=1, -> SEEK.
  - L==2 -> body is empty; go straight to the next state.
- BODY: count L-2 bytes.
  - With the parse flag, body byte index 1,2 = height hi,lo and index 3,4 = width hi,lo.
  - dim_valid goes high the cycle after index 4 is accepted.
  - If L-2<5 on SOF0: err=1, dims unchanged.
  - End of body -> SEEK, or -> ECS if the segment was SOS (ecs_done cleared on entry).
- ECS: byte != FF -> push into the accumulator; FF -> ECSFF.
- ECSFF:
  - 00 -> push 0xFF, -> ECS.
  - FF -> stay.
  - Any other byte -> ecs_done=1, then handle that byte exactly as in MARK.

Accumulator:
- 64-bit, MSB-aligned; cnt 0..64.
- bdata = acc[63:32].
- bavail = min(cnt,32).
- bvalid = (cnt>=32) | (ecs_done & cnt>0).
- Each cycle:
  - c = bvalid ? blen : 0.
  - acc <<= c, then the pushed byte is placed at bits [63-(cnt-c) -: 8].
  - cnt' = cnt - c + (push ? 8 : 0).
- If blen>bavail: consume bavail and set err=1.
- iready = 1 outside ECS/ECSFF. Inside them, iready = (cnt<=56), using the registered cnt.
- Latency: a byte accepted at cycle t is visible in bdata/bavail at t+1.
- Trailing 1-padding bits stay in the window; discarding them is the consumer's job.
- SOI flushes undrained bits. The consumer must drain before the next frame.
- Simultaneous consume and push are both applied in the same cycle.
- sof/eof pulse the cycle after the marker byte is accepted.

Test Plan:
- SOI: FF D8 -> sof=1 for exactly one cycle, one cycle after D8 is accepted; err=0; dim_valid=0.
- SOF0: FF C0 00 11 08 01 E0 02 80 03 + 9 bytes -> height=480, width=640, dim_valid=1; parser returns to SEEK after 15 body bytes.
- SOS + ECS: FF DA 00 02, then 12 FF 00 34 FF D9 -> cnt=24; bvalid=1 (ecs_done); bdata=0x12FF3400; bavail=24; eof pulse. blen=24 -> bvalid=0.
- Backpressure: 12 ECS bytes, no SOI/EOI, blen=0 -> iready=0 once cnt=64 (after 8 bytes). bdata = first 4 bytes. blen=32 -> iready=1 the next cycle; remaining bytes accepted; no loss or reorder.
- Fill and error: FF FF FF D8 -> single sof. Then FF DB 00 01 -> err=1, state SEEK. Then FF D8 -> err=0.
- Reset mid-ECS with cnt=40 -> the next cycle bvalid=0, bavail=0, iready=1, dims=0. A following FF D8 gives a normal sof.
